misao_mem_responder: RTL and testbench

//  Synthesizable memory-side responder for the MISA-O CPU bus: byte-wide RAM answering the core's
//  mem_enable_read/mem_enable_write/mem_addr requests. Includes a boot loader FSM that streams a

---
 rtl/misao_mem_responder.sv | 137 +++++++++++++
 tb/tb_misao_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/misao_mem_responder.sv
// Byte-wide RAM responder for the MISA-O core bus with a boot loader that streams an image in
// before releasing the core from reset. Define MISAO_MEM_WPROT_EN to write-protect the boot area.
module misao_mem_responder #(
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 15,
    parameter int LOAD_BASE = 0,
    parameter int WPROT_TOP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_enable_read,
    input  logic              mem_enable_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rw,
    input  logic [7:0]        mem_data_out,
    output logic [7:0]        mem_data_in,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_rst,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              bus_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] BASE_L  = (ADDR_W+1)'(LOAD_BASE);
    localparam logic [ADDR_W:0] WPROT_L = (ADDR_W+1)'(WPROT_TOP);

    typedef enum logic [1:0] {ST_LOAD, ST_RELEASE, ST_RUN} state_t;

    state_t          state_reg;
    logic            ld_ready_reg;
    logic            cpu_rst_reg;
    logic            load_done_reg;
    logic [ADDR_W:0] load_count_reg;
    logic            bus_err_reg;

    logic [7:0] ram [DEPTH];

    logic            run;
    logic [ADDR_W:0] core_addr_ext;
    logic [ADDR_W:0] ld_addr;
    logic            in_range;
    logic            wprot_hit;
    logic            ld_fire;
    logic            ld_at_top;
    logic            core_we;
    logic            err_set;
    logic            ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [7:0]      ram_wdata;
    logic            unused_sig;

    assign run           = (state_reg == ST_RUN);
    assign core_addr_ext = {1'b0, mem_addr};
    assign ld_addr       = BASE_L + load_count_reg;
    assign in_range      = (core_addr_ext < DEPTH_L);

`ifdef MISAO_MEM_WPROT_EN
    assign wprot_hit  = (core_addr_ext < WPROT_L);
    assign unused_sig = mem_rw;
`else
    assign wprot_hit  = 1'b0;
    assign unused_sig = mem_rw ^ (core_addr_ext < WPROT_L);
`endif

    assign ld_fire   = (state_reg == ST_LOAD) && ld_valid && ld_ready_reg;
    assign ld_at_top = (ld_addr == LAST_L);
    assign core_we   = run && mem_enable_write && in_range && !wprot_hit;

    // Any of: out-of-range access, simultaneous read+write, or a protected write.
    assign err_set = run && (((mem_enable_read || mem_enable_write) && !in_range)
                          || (mem_enable_read && mem_enable_write)
                          || (mem_enable_write && in_range && wprot_hit));

    // Loader and core never write in the same state, so one write port serves both.
    assign ram_we    = ld_fire || core_we;
    assign ram_waddr = ld_fire ? ld_addr[IDX_W-1:0] : mem_addr[IDX_W-1:0];
    assign ram_wdata = ld_fire ? ld_data : mem_data_out;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    // Zero-latency read: a same-cycle write is not visible until the next cycle.
    assign mem_data_in = (run && mem_enable_read && in_range) ? ram[mem_addr[IDX_W-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_LOAD;
            ld_ready_reg   <= 1'b0;
            cpu_rst_reg    <= 1'b1;
            load_done_reg  <= 1'b0;
            load_count_reg <= '0;
            bus_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    ld_ready_reg <= 1'b1;
                    cpu_rst_reg  <= 1'b1;
                    if (ld_fire) begin
                        load_count_reg <= load_count_reg + 1'b1;
                        if (ld_last || ld_at_top) begin
                            state_reg    <= ST_RELEASE;
                            ld_ready_reg <= 1'b0;
                        end
                    end
                end
                ST_RELEASE: begin
                    state_reg     <= ST_RUN;
                    ld_ready_reg  <= 1'b0;
                    cpu_rst_reg   <= 1'b0;
                    load_done_reg <= 1'b1;
                end
                ST_RUN: begin
                    if (err_set) begin
                        bus_err_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_LOAD;
                end
            endcase
        end
    end

    assign ld_ready   = ld_ready_reg;
    assign cpu_rst    = cpu_rst_reg;
    assign load_done  = load_done_reg;
    assign load_count = load_count_reg;
    assign bus_err    = bus_err_reg;
endmodule

// File: tb/tb_misao_mem_responder.sv
// Directed bench for misao_mem_responder: boot loading, RUN-state bus vectors, reset and
// protection corner cases. Expected values follow the MISAO_MEM_WPROT_EN setting.
module tb_misao_mem_responder;
    localparam int ADDR_W = 15;
`ifdef MISAO_MEM_WPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_enable_read;
    logic              mem_enable_write;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rw;
    logic [7:0]        mem_data_out;
    logic [7:0]        mem_data_in;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              cpu_rst;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              bus_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wdata;
        logic [7:0]        exp_rd;
        logic              exp_err;
    } vec_t;

    vec_t vec_c [12];
    vec_t vec_d [6];
    vec_t vec_e [12];

    misao_mem_responder #(
        .DEPTH(256), .ADDR_W(ADDR_W), .LOAD_BASE(0), .WPROT_TOP(16)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
        .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .cpu_rst(cpu_rst), .load_done(load_done), .load_count(load_count), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drive one core bus cycle, check the combinational read, then the sticky error after the edge.
    task automatic run_vec(input vec_t v, input string tag);
        mem_enable_read  = v.rd;
        mem_enable_write = v.wr;
        mem_rw           = v.wr;
        mem_addr         = v.addr;
        mem_data_out     = v.wdata;
        #3;
        check({tag, "_rdata"}, {24'h0, mem_data_in}, {24'h0, v.exp_rd});
        $display("%s: rd=%0b wr=%0b addr=0x%04h wdata=0x%02h data_in=0x%02h", tag, v.rd, v.wr,
                 v.addr, v.wdata, mem_data_in);
        tick();
        check({tag, "_bus_err"}, {31'h0, bus_err}, {31'h0, v.exp_err});
        mem_enable_read  = 1'b0;
        mem_enable_write = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ready_low;
        // RUN bus vectors after a full-memory image (bytes 0..15 = 0xC0+i, the rest 0x00).
        vec_c[0]  = '{1'b1, 1'b0, 15'h0000, 8'h00, 8'hC0, 1'b0};
        vec_c[1]  = '{1'b1, 1'b0, 15'h000F, 8'h00, 8'hCF, 1'b0};
        vec_c[2]  = '{1'b1, 1'b0, 15'h00FF, 8'h00, 8'h00, 1'b0};
        vec_c[3]  = '{1'b1, 1'b0, 15'h0082, 8'h00, 8'h00, 1'b0};
        vec_c[4]  = '{1'b0, 1'b1, 15'h0081, 8'h5B, 8'h00, 1'b0};
        vec_c[5]  = '{1'b1, 1'b0, 15'h0081, 8'h00, 8'h5B, 1'b0};
        vec_c[6]  = '{1'b0, 1'b1, 15'h0010, 8'h33, 8'h00, 1'b0};
        vec_c[7]  = '{1'b1, 1'b0, 15'h0010, 8'h00, 8'h33, 1'b0};
        vec_c[8]  = '{1'b0, 1'b1, 15'h0005, 8'h12, 8'h00, PROT};
        vec_c[9]  = '{1'b1, 1'b0, 15'h0005, 8'h00, (PROT ? 8'hC5 : 8'h12), PROT};
        vec_c[10] = '{1'b1, 1'b1, 15'h0020, 8'h44, 8'h00, 1'b1};
        vec_c[11] = '{1'b1, 1'b0, 15'h0020, 8'h00, 8'h44, 1'b1};
        // After reload of 0xAA,0xBB: RAM not cleared, out-of-range accesses flagged.
        vec_d[0]  = '{1'b1, 1'b0, 15'h0000, 8'h00, 8'hAA, 1'b0};
        vec_d[1]  = '{1'b1, 1'b0, 15'h0001, 8'h00, 8'hBB, 1'b0};
        vec_d[2]  = '{1'b1, 1'b0, 15'h0002, 8'h00, 8'hC2, 1'b0};
        vec_d[3]  = '{1'b1, 1'b0, 15'h0100, 8'h00, 8'h00, 1'b1};
        vec_d[4]  = '{1'b0, 1'b1, 15'h7FFF, 8'h99, 8'h00, 1'b1};
        vec_d[5]  = '{1'b1, 1'b0, 15'h00FF, 8'h00, 8'h00, 1'b1};
        // After the gapped 11-byte load (0x60+i); byte 11 keeps the earlier image value.
        for (int i = 0; i < 11; i++)
            vec_e[i] = '{1'b1, 1'b0, ADDR_W'(i), 8'h00, 8'h60 + 8'(i), 1'b0};
        vec_e[11] = '{1'b1, 1'b0, 15'h000B, 8'h00, 8'hCB, 1'b0};

        rst = 1'b1;
        mem_enable_read = 1'b1; mem_enable_write = 1'b0; mem_addr = '0; mem_rw = 1'b0;
        mem_data_out = 8'h00; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
        tick();
        tick();
        check("rst_ld_ready",   {31'h0, ld_ready},  32'h0);
        check("rst_cpu_rst",    {31'h0, cpu_rst},   32'h1);
        check("rst_load_done",  {31'h0, load_done}, 32'h0);
        check("rst_load_count", {16'h0, load_count}, 32'h0);
        check("rst_bus_err",    {31'h0, bus_err},   32'h0);
        check("rst_rdata",      {24'h0, mem_data_in}, 32'h0);
        mem_enable_read = 1'b0;
        rst = 1'b0;
        tick();
        check("ld_ready_after_rst", {31'h0, ld_ready}, 32'h1);

        // Full-memory image without ld_last: the load must end at address DEPTH-1.
        ready_low = 0;
        for (int i = 0; i < 256; i++) begin
            if (ld_ready !== 1'b1) ready_low++;
            load_byte((i < 16) ? 8'hC0 + 8'(i) : 8'h00, 1'b0);
        end
        check("full_ready_low_cycles", ready_low, 0);
        check("full_load_count", {16'h0, load_count}, 32'h100);
        check("full_release_ready", {31'h0, ld_ready}, 32'h0);
        check("full_release_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        ld_valid = 1'b1; ld_data = 8'hEE;
        tick();
        check("full_run_cpu_rst", {31'h0, cpu_rst}, 32'h0);
        check("full_run_load_done", {31'h0, load_done}, 32'h1);
        tick();
        tick();
        check("full_no_extra_bytes", {16'h0, load_count}, 32'h100);
        ld_valid = 1'b0;
        for (int i = 0; i < 12; i++) run_vec(vec_c[i], $sformatf("run_vec%0d", i));

        // Reset clears the sticky error; then abort a load midway and reload.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_clears_bus_err", {31'h0, bus_err}, 32'h0);
        tick();
        load_byte(8'h11, 1'b0);
        mem_enable_read = 1'b1; mem_addr = 15'h0000;
        #1;
        check("load_bus_ignored", {24'h0, mem_data_in}, 32'h0);
        mem_enable_read = 1'b0;
        load_byte(8'h22, 1'b0);
        check("partial_count", {16'h0, load_count}, 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midload_rst_count", {16'h0, load_count}, 32'h0);
        tick();
        load_byte(8'hAA, 1'b0);
        load_byte(8'hBB, 1'b1);
        check("reload_count", {16'h0, load_count}, 32'h2);
        check("reload_cpu_rst_hold", {31'h0, cpu_rst}, 32'h1);
        tick();
        check("reload_cpu_rst_fall", {31'h0, cpu_rst}, 32'h0);
        for (int i = 0; i < 6; i++) run_vec(vec_d[i], $sformatf("reload_vec%0d", i));

        // Gapped loader: valid one cycle in three, ld_ready must stay high throughout.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        ready_low = 0;
        for (int i = 0; i < 11; i++) begin
            for (int g = 0; g < 2; g++) begin
                if (ld_ready !== 1'b1) ready_low++;
                tick();
            end
            if (ld_ready !== 1'b1) ready_low++;
            load_byte(8'h60 + 8'(i), (i == 10));
        end
        check("gap_ready_low_cycles", ready_low, 0);
        check("gap_load_count", {16'h0, load_count}, 32'hB);
        tick();
        check("gap_load_done", {31'h0, load_done}, 32'h1);
        for (int i = 0; i < 12; i++) run_vec(vec_e[i], $sformatf("gap_vec%0d", i));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
